// File: rtl/control_sequencer_if.sv
// control_sequencer_if: bundles the sequencer's inputs (run, IR, optional step)
// and every control strobe it drives toward the bus datapath.
// Optional feature macro: SINGLE_STEP_EN (adds the step input).
interface control_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             run;
   logic [31:0]      ir;
`ifdef SINGLE_STEP_EN
   logic             step;
`endif
   logic [7:0]       out_en;
   logic [9:0]       in_en;
   logic [2:0]       gr_sel;
   logic             rin;
   logic             rout;
   logic             ba_out;
   logic             inc_pc;
   logic             mem_rd;
   logic             mem_wr;
   logic [1:0]       mdr_sel;
   logic [3:0]       alu_op;
   logic             busy;
   logic             halted;
   logic [CNT_W-1:0] instr_count;

`ifdef SINGLE_STEP_EN
   modport master (
      input  run, ir, step,
      output out_en, in_en, gr_sel, rin, rout, ba_out, inc_pc,
             mem_rd, mem_wr, mdr_sel, alu_op, busy, halted, instr_count
   );
   modport slave (
      output run, ir, step,
      input  out_en, in_en, gr_sel, rin, rout, ba_out, inc_pc,
             mem_rd, mem_wr, mdr_sel, alu_op, busy, halted, instr_count
   );
`else
   modport master (
      input  run, ir,
      output out_en, in_en, gr_sel, rin, rout, ba_out, inc_pc,
             mem_rd, mem_wr, mdr_sel, alu_op, busy, halted, instr_count
   );
   modport slave (
      output run, ir,
      input  out_en, in_en, gr_sel, rin, rout, ba_out, inc_pc,
             mem_rd, mem_wr, mdr_sel, alu_op, busy, halted, instr_count
   );
`endif
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the 32-bit bus datapath.
// Fetch T0-T2, execute T3-T7 decoded from IR[31:27]; optional RAM wait states;
// counts retired instructions; HALT is left only through reset.
// Optional feature macro: SINGLE_STEP_EN (one instruction per rising edge of step).
module control_sequencer #(
   parameter int MEM_WAIT = 0,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   control_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_WAIT, S_HALT
   } state_t;

   localparam int WC_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

   // out_en bit positions
   localparam int OE_PC   = 7;
   localparam int OE_MDR  = 6;
   localparam int OE_ZLO  = 5;
   localparam int OE_ZHI  = 4;
   localparam int OE_HI   = 3;
   localparam int OE_LO   = 2;
   localparam int OE_INP  = 1;
   localparam int OE_C    = 0;
   // in_en bit positions
   localparam int IE_PC   = 9;
   localparam int IE_MAR  = 8;
   localparam int IE_MDR  = 7;
   localparam int IE_IR   = 6;
   localparam int IE_Y    = 5;
   localparam int IE_ZLO  = 4;
   localparam int IE_ZHI  = 3;
   localparam int IE_HI   = 2;
   localparam int IE_LO   = 1;
   localparam int IE_OUTP = 0;
   // gr_sel bit positions
   localparam int GR_A    = 2;
   localparam int GR_B    = 1;
   localparam int GR_C    = 0;

   localparam logic [1:0] MDR_BUS = 2'b00;
   localparam logic [1:0] MDR_RAM = 2'b01;

   state_t           r_state;
   state_t           w_state_next;
   state_t           w_after_retire;
   logic [WC_W-1:0]  r_wait_cnt;
   logic [WC_W-1:0]  w_wait_cnt_next;
   logic             r_wait_exec;      // 1: the wait belongs to ld T6, 0: to fetch T1
   logic             w_wait_exec_next;
   logic [CNT_W-1:0] r_instr_count;
   logic             w_retire;
   logic             w_start;

   logic [4:0]       w_opcode;
   logic             w_op_rtype, w_op_imm, w_op_muldiv, w_op_unary;
   logic             w_op_ld, w_op_ldi, w_op_st, w_op_addr;
   logic             w_op_in, w_op_out, w_op_mfhi, w_op_mflo, w_op_halt, w_op_exec;
   logic [3:0]       w_alu_code;

   logic [7:0]       w_out_en;
   logic [9:0]       w_in_en;
   logic [2:0]       w_gr_sel;
   logic             w_rin, w_rout, w_ba_out, w_inc_pc, w_mem_rd, w_mem_wr;
   logic [1:0]       w_mdr_sel;
   logic [3:0]       w_alu_op;

   assign w_opcode = bus.ir[31:27];

`ifdef SINGLE_STEP_EN
   logic r_step_prev;
   logic w_unused_in;

   // Registered copy of step for rising-edge detection; an edge outside IDLE is simply lost
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_step_prev <= 1'b0;
      else        r_step_prev <= bus.step;
   end

   assign w_start        = bus.step & ~r_step_prev;
   assign w_after_retire = S_IDLE;
   assign w_unused_in    = ^{bus.ir[26:0], bus.run};
`else
   logic w_unused_in;
   assign w_start        = bus.run;
   assign w_after_retire = bus.run ? S_T0 : S_IDLE;
   assign w_unused_in    = ^bus.ir[26:0];
`endif

   // Opcode classes and the ALU operation each arithmetic opcode selects
   always_comb begin
      w_op_ld     = (w_opcode == 5'h00);
      w_op_ldi    = (w_opcode == 5'h01);
      w_op_st     = (w_opcode == 5'h02);
      w_op_rtype  = (w_opcode >= 5'h03) && (w_opcode <= 5'h0A);
      w_op_imm    = (w_opcode >= 5'h0B) && (w_opcode <= 5'h0D);
      w_op_muldiv = (w_opcode == 5'h0E) || (w_opcode == 5'h0F);
      w_op_unary  = (w_opcode == 5'h10) || (w_opcode == 5'h11);
      w_op_in     = (w_opcode == 5'h16);
      w_op_out    = (w_opcode == 5'h17);
      w_op_mfhi   = (w_opcode == 5'h18);
      w_op_mflo   = (w_opcode == 5'h19);
      w_op_halt   = (w_opcode == 5'h1B);
      w_op_addr   = w_op_ld | w_op_ldi | w_op_st;
      w_op_exec   = w_op_addr | w_op_rtype | w_op_imm | w_op_muldiv | w_op_unary |
                    w_op_in | w_op_out | w_op_mfhi | w_op_mflo;
      case (w_opcode)
         5'h03:   w_alu_code = 4'd0;   // add
         5'h04:   w_alu_code = 4'd1;   // sub
         5'h05:   w_alu_code = 4'd4;   // shr
         5'h06:   w_alu_code = 4'd5;   // shl
         5'h07:   w_alu_code = 4'd6;   // ror
         5'h08:   w_alu_code = 4'd7;   // rol
         5'h09:   w_alu_code = 4'd2;   // and
         5'h0A:   w_alu_code = 4'd3;   // or
         5'h0B:   w_alu_code = 4'd0;   // addi
         5'h0C:   w_alu_code = 4'd2;   // andi
         5'h0D:   w_alu_code = 4'd3;   // ori
         5'h0E:   w_alu_code = 4'd8;   // mul
         5'h0F:   w_alu_code = 4'd9;   // div
         5'h10:   w_alu_code = 4'd10;  // neg
         5'h11:   w_alu_code = 4'd11;  // not
         default: w_alu_code = 4'd0;
      endcase
   end

   // Moore decode: strobes and next state from the state register and opcode only
   always_comb begin
      w_out_en         = '0;
      w_in_en          = '0;
      w_gr_sel         = '0;
      w_rin            = 1'b0;
      w_rout           = 1'b0;
      w_ba_out         = 1'b0;
      w_inc_pc         = 1'b0;
      w_mem_rd         = 1'b0;
      w_mem_wr         = 1'b0;
      w_mdr_sel        = MDR_BUS;
      w_alu_op         = 4'd0;
      w_retire         = 1'b0;
      w_state_next     = r_state;
      w_wait_cnt_next  = r_wait_cnt;
      w_wait_exec_next = r_wait_exec;

      case (r_state)
         S_IDLE: begin
            if (w_start) w_state_next = S_T0;
         end
         S_T0: begin
            w_out_en[OE_PC]  = 1'b1;
            w_in_en[IE_MAR]  = 1'b1;
            w_inc_pc         = 1'b1;
            w_in_en[IE_ZLO]  = 1'b1;
            w_state_next     = S_T1;
         end
         S_T1: begin
            w_mem_rd  = 1'b1;
            w_mdr_sel = MDR_RAM;
            if (MEM_WAIT == 0) begin
               w_out_en[OE_ZLO] = 1'b1;
               w_in_en[IE_PC]   = 1'b1;
               w_in_en[IE_MDR]  = 1'b1;
               w_state_next     = S_T2;
            end else begin
               // slow RAM: hold the read, commit nothing until the last wait cycle
               w_wait_cnt_next  = '0;
               w_wait_exec_next = 1'b0;
               w_state_next     = S_WAIT;
            end
         end
         S_WAIT: begin
            w_mem_rd  = 1'b1;
            w_mdr_sel = MDR_RAM;
            if (r_wait_cnt == WAIT_LAST) begin
               w_in_en[IE_MDR] = 1'b1;
               if (r_wait_exec) begin
                  w_state_next = S_T7;
               end else begin
                  w_out_en[OE_ZLO] = 1'b1;
                  w_in_en[IE_PC]   = 1'b1;
                  w_state_next     = S_T2;
               end
            end else begin
               w_wait_cnt_next = r_wait_cnt + WC_W'(1);
            end
         end
         S_T2: begin
            w_out_en[OE_MDR] = 1'b1;
            w_in_en[IE_IR]   = 1'b1;
            if (w_op_halt)      w_state_next = S_HALT;
            else if (w_op_exec) w_state_next = S_T3;
            else                w_retire     = 1'b1;   // nop and undefined opcodes
         end
         S_T3: begin
            if (w_op_addr) begin
               // base register via BAout so that R0 contributes zero
               w_gr_sel[GR_B] = 1'b1;
               w_ba_out       = 1'b1;
               w_in_en[IE_Y]  = 1'b1;
               w_state_next   = S_T4;
            end else if (w_op_rtype || w_op_imm || w_op_muldiv) begin
               w_gr_sel[GR_B] = 1'b1;
               w_rout         = 1'b1;
               w_in_en[IE_Y]  = 1'b1;
               w_state_next   = S_T4;
            end else if (w_op_unary) begin
               w_gr_sel[GR_B]  = 1'b1;
               w_rout          = 1'b1;
               w_alu_op        = w_alu_code;
               w_in_en[IE_ZLO] = 1'b1;
               w_state_next    = S_T4;
            end else if (w_op_in) begin
               w_out_en[OE_INP] = 1'b1;
               w_gr_sel[GR_A]   = 1'b1;
               w_rin            = 1'b1;
               w_retire         = 1'b1;
            end else if (w_op_out) begin
               w_gr_sel[GR_A]   = 1'b1;
               w_rout           = 1'b1;
               w_in_en[IE_OUTP] = 1'b1;
               w_retire         = 1'b1;
            end else if (w_op_mfhi || w_op_mflo) begin
               w_out_en[OE_HI]  = w_op_mfhi;
               w_out_en[OE_LO]  = w_op_mflo;
               w_gr_sel[GR_A]   = 1'b1;
               w_rin            = 1'b1;
               w_retire         = 1'b1;
            end else begin
               w_retire = 1'b1;
            end
         end
         S_T4: begin
            if (w_op_rtype) begin
               w_gr_sel[GR_C]  = 1'b1;
               w_rout          = 1'b1;
               w_alu_op        = w_alu_code;
               w_in_en[IE_ZLO] = 1'b1;
               w_state_next    = S_T5;
            end else if (w_op_muldiv) begin
               w_gr_sel[GR_A]  = 1'b1;
               w_rout          = 1'b1;
               w_alu_op        = w_alu_code;
               w_in_en[IE_ZLO] = 1'b1;
               w_in_en[IE_ZHI] = 1'b1;
               w_state_next    = S_T5;
            end else if (w_op_imm || w_op_addr) begin
               // immediate/offset from C; address forms always add
               w_out_en[OE_C]  = 1'b1;
               w_alu_op        = w_op_imm ? w_alu_code : 4'd0;
               w_in_en[IE_ZLO] = 1'b1;
               w_state_next    = S_T5;
            end else if (w_op_unary) begin
               w_out_en[OE_ZLO] = 1'b1;
               w_gr_sel[GR_A]   = 1'b1;
               w_rin            = 1'b1;
               w_retire         = 1'b1;
            end else begin
               w_retire = 1'b1;
            end
         end
         S_T5: begin
            w_out_en[OE_ZLO] = 1'b1;
            if (w_op_muldiv) begin
               w_in_en[IE_LO] = 1'b1;
               w_state_next   = S_T6;
            end else if (w_op_ld || w_op_st) begin
               w_in_en[IE_MAR] = 1'b1;
               w_state_next    = S_T6;
            end else begin
               w_gr_sel[GR_A] = 1'b1;
               w_rin          = 1'b1;
               w_retire       = 1'b1;
            end
         end
         S_T6: begin
            if (w_op_muldiv) begin
               w_out_en[OE_ZHI] = 1'b1;
               w_in_en[IE_HI]   = 1'b1;
               w_retire         = 1'b1;
            end else if (w_op_ld) begin
               w_mem_rd  = 1'b1;
               w_mdr_sel = MDR_RAM;
               if (MEM_WAIT == 0) begin
                  w_in_en[IE_MDR] = 1'b1;
                  w_state_next    = S_T7;
               end else begin
                  w_wait_cnt_next  = '0;
                  w_wait_exec_next = 1'b1;
                  w_state_next     = S_WAIT;
               end
            end else if (w_op_st) begin
               w_gr_sel[GR_A]  = 1'b1;
               w_rout          = 1'b1;
               w_mdr_sel       = MDR_BUS;
               w_in_en[IE_MDR] = 1'b1;
               w_state_next    = S_T7;
            end else begin
               w_retire = 1'b1;
            end
         end
         S_T7: begin
            if (w_op_ld) begin
               w_out_en[OE_MDR] = 1'b1;
               w_gr_sel[GR_A]   = 1'b1;
               w_rin            = 1'b1;
            end else if (w_op_st) begin
               w_mem_wr = 1'b1;
            end
            w_retire = 1'b1;
         end
         S_HALT: begin
            w_state_next = S_HALT;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      if (w_retire) w_state_next = w_after_retire;
   end

   // State, wait counter and retire counter; reset abandons any instruction in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_wait_cnt    <= '0;
         r_wait_exec   <= 1'b0;
         r_instr_count <= '0;
      end else begin
         r_state     <= w_state_next;
         r_wait_cnt  <= w_wait_cnt_next;
         r_wait_exec <= w_wait_exec_next;
         if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
      end
   end

   assign bus.out_en      = w_out_en;
   assign bus.in_en       = w_in_en;
   assign bus.gr_sel      = w_gr_sel;
   assign bus.rin         = w_rin;
   assign bus.rout        = w_rout;
   assign bus.ba_out      = w_ba_out;
   assign bus.inc_pc      = w_inc_pc;
   assign bus.mem_rd      = w_mem_rd;
   assign bus.mem_wr      = w_mem_wr;
   assign bus.mdr_sel     = w_mdr_sel;
   assign bus.alu_op      = w_alu_op;
   assign bus.busy        = (r_state != S_IDLE) && (r_state != S_HALT);
   assign bus.halted      = (r_state == S_HALT);
   assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: drives two sequencers (single-cycle RAM, 16-bit count;
// two-cycle RAM wait, 4-bit count) one at a time, comparing every cycle's
// strobes against per-opcode micro-step lists built from the instruction table.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        reset0, reset2;
   logic        run;
   logic [31:0] ir;
   logic        sel;            // 0: observe u_dut0, 1: observe u_dut2
   int          wait_n;
   logic [15:0] cnt_mask;
   logic [15:0] cnt_model;
   int          n_cmp = 0;
   int          n_mis = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   control_sequencer_if #(.CNT_W(16)) if0 ();
   control_sequencer_if #(.CNT_W(4))  if2 ();

   assign if0.run = run;
   assign if0.ir  = ir;
   assign if2.run = run;
   assign if2.ir  = ir;
`ifdef SINGLE_STEP_EN
   logic step;
   assign if0.step = step;
   assign if2.step = step;
`endif

   control_sequencer #(.MEM_WAIT(0), .CNT_W(16)) u_dut0 (.clk(clk), .reset(reset0), .bus(if0));
   control_sequencer #(.MEM_WAIT(2), .CNT_W(4))  u_dut2 (.clk(clk), .reset(reset2), .bus(if2));

   // observed strobes packed {out_en, in_en, gr_sel, rin, rout, ba_out, inc_pc, mem_rd, mem_wr, mdr_sel, alu_op}
   logic [32:0] vec0, vec2, obs_vec;
   logic        obs_busy, obs_halted;
   logic [15:0] obs_cnt;
   assign vec0 = {if0.out_en, if0.in_en, if0.gr_sel, if0.rin, if0.rout, if0.ba_out, if0.inc_pc,
                  if0.mem_rd, if0.mem_wr, if0.mdr_sel, if0.alu_op};
   assign vec2 = {if2.out_en, if2.in_en, if2.gr_sel, if2.rin, if2.rout, if2.ba_out, if2.inc_pc,
                  if2.mem_rd, if2.mem_wr, if2.mdr_sel, if2.alu_op};
   assign obs_vec    = sel ? vec2 : vec0;
   assign obs_busy   = sel ? if2.busy : if0.busy;
   assign obs_halted = sel ? if2.halted : if0.halted;
   assign obs_cnt    = sel ? {12'd0, if2.instr_count} : if0.instr_count;

   localparam logic [32:0] B1 = 33'd1;
   localparam logic [32:0] PCOUT = B1 << 32, MDROUT = B1 << 31, ZLOWOUT = B1 << 30, ZHIGHOUT = B1 << 29;
   localparam logic [32:0] HIOUT = B1 << 28, LOOUT = B1 << 27, INPORTOUT = B1 << 26, COUT = B1 << 25;
   localparam logic [32:0] PCIN = B1 << 24, MARIN = B1 << 23, MDRIN = B1 << 22, IRIN = B1 << 21;
   localparam logic [32:0] YIN = B1 << 20, ZLOWIN = B1 << 19, ZHIGHIN = B1 << 18, HIIN = B1 << 17;
   localparam logic [32:0] LOIN = B1 << 16, OUTPORTIN = B1 << 15;
   localparam logic [32:0] GRA = B1 << 14, GRB = B1 << 13, GRC = B1 << 12;
   localparam logic [32:0] RIN = B1 << 11, ROUT = B1 << 10, BAOUT = B1 << 9, INCPC = B1 << 8;
   localparam logic [32:0] MEMRD = B1 << 7, MEMWR = B1 << 6, MDR_RAM = B1 << 4;
   localparam logic [32:0] RD_HOLD = MEMRD | MDR_RAM;

   function automatic logic [3:0] alu_of(input logic [4:0] op);
      case (op)
         5'h03, 5'h0B: return 4'd0;
         5'h04:        return 4'd1;
         5'h09, 5'h0C: return 4'd2;
         5'h0A, 5'h0D: return 4'd3;
         5'h05:        return 4'd4;
         5'h06:        return 4'd5;
         5'h07:        return 4'd6;
         5'h08:        return 4'd7;
         5'h0E:        return 4'd8;
         5'h0F:        return 4'd9;
         5'h10:        return 4'd10;
         5'h11:        return 4'd11;
         default:      return 4'd0;
      endcase
   endfunction

   // expected cycle-by-cycle strobes of one instruction, RAM reads stretched by wait_n
   task automatic build(input logic [4:0] op);
      logic [32:0] a;
      a = {29'd0, alu_of(op)};
      exp_q.delete();
      exp_q.push_back(PCOUT | MARIN | INCPC | ZLOWIN);
      for (int k = 0; k < wait_n; k++) exp_q.push_back(RD_HOLD);
      exp_q.push_back(ZLOWOUT | PCIN | MDRIN | RD_HOLD);
      exp_q.push_back(MDROUT | IRIN);
      if (op >= 5'h03 && op <= 5'h0A) begin
         exp_q.push_back(GRB | ROUT | YIN);
         exp_q.push_back(GRC | ROUT | ZLOWIN | a);
         exp_q.push_back(ZLOWOUT | GRA | RIN);
      end else if (op >= 5'h0B && op <= 5'h0D) begin
         exp_q.push_back(GRB | ROUT | YIN);
         exp_q.push_back(COUT | ZLOWIN | a);
         exp_q.push_back(ZLOWOUT | GRA | RIN);
      end else if (op == 5'h0E || op == 5'h0F) begin
         exp_q.push_back(GRB | ROUT | YIN);
         exp_q.push_back(GRA | ROUT | ZLOWIN | ZHIGHIN | a);
         exp_q.push_back(ZLOWOUT | LOIN);
         exp_q.push_back(ZHIGHOUT | HIIN);
      end else if (op == 5'h10 || op == 5'h11) begin
         exp_q.push_back(GRB | ROUT | ZLOWIN | a);
         exp_q.push_back(ZLOWOUT | GRA | RIN);
      end else if (op <= 5'h02) begin
         exp_q.push_back(GRB | BAOUT | YIN);
         exp_q.push_back(COUT | ZLOWIN);
         if (op == 5'h01) begin
            exp_q.push_back(ZLOWOUT | GRA | RIN);
         end else begin
            exp_q.push_back(ZLOWOUT | MARIN);
            if (op == 5'h00) begin
               for (int k = 0; k < wait_n; k++) exp_q.push_back(RD_HOLD);
               exp_q.push_back(RD_HOLD | MDRIN);
               exp_q.push_back(MDROUT | GRA | RIN);
            end else begin
               exp_q.push_back(GRA | ROUT | MDRIN);
               exp_q.push_back(MEMWR);
            end
         end
      end else if (op == 5'h16) exp_q.push_back(INPORTOUT | GRA | RIN);
      else if (op == 5'h17)     exp_q.push_back(GRA | ROUT | OUTPORTIN);
      else if (op == 5'h18)     exp_q.push_back(HIOUT | GRA | RIN);
      else if (op == 5'h19)     exp_q.push_back(LOOUT | GRA | RIN);
   endtask

   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start();
`ifdef SINGLE_STEP_EN
      step = 1'b1;
      tick();
      step = 1'b0;
`else
      run = 1'b1;
      tick();
`endif
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_vec"}, obs_vec, 33'd0);
      chk({tag, "_flags"}, {31'd0, obs_halted, obs_busy}, 33'd0);
   endtask

   // entered at the negedge of T0; leaves at the negedge of the next T0 (or in HALT)
   task automatic run_instr(input logic [31:0] ir_val, input logic run_after);
      logic [4:0] op;
      int         n;
      bit         goes_idle;
      op = ir_val[31:27];
      ir = ir_val;
      build(op);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("op%02h_t%0d", op, i), obs_vec, exp_q[i]);
         chk($sformatf("op%02h_busy%0d", op, i), {32'd0, obs_busy}, 33'd1);
         run = (i == n - 1) ? run_after : 1'($urandom_range(0, 1));
`ifdef SINGLE_STEP_EN
         step = (i == 1);   // edge while busy must be ignored
`endif
         tick();
      end
      if (op == 5'h1B) begin
         run = 1'b1;
         for (int k = 0; k < 4; k++) begin
            chk("halt_vec", obs_vec, 33'd0);
            chk("halt_flags", {31'd0, obs_halted, obs_busy}, 33'b10);
            chk("halt_cnt", {17'd0, obs_cnt}, {17'd0, cnt_model});
            tick();
         end
      end else begin
         cnt_model = (cnt_model + 16'd1) & cnt_mask;
         chk("count", {17'd0, obs_cnt}, {17'd0, cnt_model});
`ifdef SINGLE_STEP_EN
         goes_idle = 1'b1;
`else
         goes_idle = !run_after;
`endif
         if (goes_idle) begin
            chk_idle("retire_idle");
            run = 1'b1;
`ifdef SINGLE_STEP_EN
            tick();
            chk_idle("step_wait_idle");
`endif
            start();
         end
      end
      $display("instr dut=%0d op=%02h cycles=%0d count=%0d run_after=%0d",
               sel ? 2 : 0, op, n, obs_cnt, run_after);
   endtask

   initial begin
      logic [4:0] op;
      reset0 = 1'b0; reset2 = 1'b0; run = 1'b0; ir = '0; sel = 1'b0;
      wait_n = 0; cnt_mask = 16'hFFFF; cnt_model = '0;
`ifdef SINGLE_STEP_EN
      step = 1'b0;
`endif
      repeat (2) @(negedge clk);
      reset0 = 1'b1;
      chk_idle("reset0");
      chk("reset0_cnt", {17'd0, obs_cnt}, 33'd0);
      tick();
      chk_idle("idle_run0");
      start();

      // add R1,R2,R3: six cycles
      run_instr(32'h18918000, 1'b1);

      // reset asserted in T4 of add clears everything immediately
      ir = 32'h18918000;
      repeat (4) tick();
      chk("abort_t4", obs_vec, GRC | ROUT | ZLOWIN);
      reset0 = 1'b0;
      #1;
      chk_idle("abort_reset");
      chk("abort_cnt", {17'd0, obs_cnt}, 33'd0);
      cnt_model = '0;
      @(negedge clk);
      reset0 = 1'b1;
      start();
      chk("t0_after_reset", obs_vec, PCOUT | MARIN | INCPC | ZLOWIN);

      run_instr(32'h18918000, 1'b0);
      run_instr(32'h71A00000, 1'b1);   // mul R3,R4
      for (int i = 0; i < 40; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'h1B) op = 5'h1A;
         run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 3) != 0));
      end
      run_instr(32'hD8000000, 1'b1);   // halt

      // second sequencer: two-cycle RAM wait, 4-bit wrapping count
      reset0 = 1'b0; sel = 1'b1; wait_n = 2; cnt_mask = 16'h000F; cnt_model = '0; run = 1'b0;
      @(negedge clk);
      reset2 = 1'b1;
      chk_idle("reset2");
      chk("reset2_cnt", {17'd0, obs_cnt}, 33'd0);
      start();
      run_instr({5'h00, 27'($urandom)}, 1'b1);   // ld: twelve cycles
      run_instr({5'h02, 27'($urandom)}, 1'b1);   // st
      for (int i = 0; i < 30; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'h1B) op = 5'h1A;
         run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 3) != 0));
      end
      run_instr(32'hD8000000, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
